// File: rtl/simple_fir_pkg.sv
// rtl/simple_fir_pkg.sv - shared widths, types and round/saturate helpers for the FIR datapath
package simple_fir_pkg;

    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int NTAPS     = 4;
    localparam int OUT_SHIFT = 15;
    localparam int PROD_W    = DATA_W + COEF_W;
    localparam int ACC_W     = DATA_W + COEF_W + 2;

    typedef logic signed [DATA_W-1:0]       sample_t;
    typedef logic signed [COEF_W-1:0]       coef_t;
    typedef logic signed [PROD_W-1:0]       prod_t;
    typedef logic signed [ACC_W-1:0]        acc_t;
    typedef logic [NTAPS*COEF_W-1:0]        coef_vec_t;

    typedef struct packed {
        sample_t value;
        logic    sat;
    } sat_result_t;

    function automatic acc_t ROUND_CONST();
        acc_t r;
        r = '0;
        r[OUT_SHIFT-1] = 1'b1;
        return r;
    endfunction

    function automatic sat_result_t sat_to_width(input acc_t v);
        sat_result_t res;
        sample_t     max_s;
        sample_t     min_s;
        max_s     = {1'b0, {(DATA_W-1){1'b1}}};
        min_s     = {1'b1, {(DATA_W-1){1'b0}}};
        res.value = v[DATA_W-1:0];
        res.sat   = 1'b0;
        if (v > acc_t'(max_s)) begin
            res.value = max_s;
            res.sat   = 1'b1;
        end else if (v < acc_t'(min_s)) begin
            res.value = min_s;
            res.sat   = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/simple_fir_stream_round_sat.sv
// rtl/simple_fir_stream_round_sat.sv - combinational round-half-up, arithmetic shift and saturate
module fir_round_sat
    import simple_fir_pkg::*;
(
    input  acc_t    i_acc,
    output sample_t o_data,
    output logic    o_sat
);

    acc_t        w_rounded;
    acc_t        w_shifted;
    sat_result_t w_res;

    assign w_rounded = i_acc + ROUND_CONST();
    assign w_shifted = w_rounded >>> OUT_SHIFT;
    assign w_res     = sat_to_width(w_shifted);
    assign o_data    = w_res.value;
    assign o_sat     = w_res.sat;

endmodule

// File: rtl/simple_fir_stream.sv
// rtl/simple_fir_stream.sv - 4-tap streaming FIR: delay line, product, round/saturate stages
module simple_fir_stream
    import simple_fir_pkg::*;
(
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    cfg_enable,
    input  logic [NTAPS*COEF_W-1:0] cfg_coef,
    input  logic                    cfg_coef_load,
    input  logic                    cfg_clear,
    input  logic [DATA_W-1:0]       s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [DATA_W-1:0]       m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic [31:0]             sample_count,
    output logic                    overflow,
    output logic                    coef_pending
);

    sample_t     r_x    [NTAPS];
    coef_t       r_coef [NTAPS];
    prod_t       r_prod [NTAPS];
    logic        r_s0_valid, r_s0_last;
    logic        r_s1_valid, r_s1_last;
    logic        r_m_valid, r_m_last;
    sample_t     r_m_data;
    logic [31:0] r_count;
    logic        r_overflow;
    logic        r_pkt_open, r_pending, r_apply;

    logic        w_adv, w_accept, w_closing, w_req, w_sat;
    acc_t        w_sum;
    sample_t     w_rs_data;

    assign w_adv     = !r_m_valid || m_axis_tready;
    assign s_axis_tready = w_adv && cfg_enable && !ARESET;
    assign w_accept  = s_axis_tvalid && s_axis_tready;
    assign w_closing = w_accept && s_axis_tlast;
    assign w_req     = cfg_coef_load || r_pending;

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NTAPS; k++) begin
            w_sum = w_sum + acc_t'(r_prod[k]);
        end
    end

    fir_round_sat u_round_sat (
        .i_acc  (w_sum),
        .o_data (w_rs_data),
        .o_sat  (w_sat)
    );

    // Stage 0: delay line; clear zeroes history but a coincident sample still lands in x0
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int k = 0; k < NTAPS; k++) r_x[k] <= '0;
            r_s0_valid <= 1'b0;
            r_s0_last  <= 1'b0;
        end else begin
            if (w_adv) begin
                r_s0_valid <= w_accept;
                r_s0_last  <= w_accept && s_axis_tlast;
            end
            if (cfg_clear) begin
                for (int k = 0; k < NTAPS; k++) r_x[k] <= '0;
            end
            if (w_accept) begin
                r_x[0] <= s_axis_tdata;
                if (!cfg_clear) begin
                    for (int k = 1; k < NTAPS; k++) r_x[k] <= r_x[k-1];
                end
            end
        end
    end

    // A load requested mid-packet waits for the tlast accept, then captures one cycle later
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int k = 0; k < NTAPS; k++) r_coef[k] <= '0;
            r_pkt_open <= 1'b0;
            r_pending  <= 1'b0;
            r_apply    <= 1'b0;
        end else begin
            if (w_accept) r_pkt_open <= !s_axis_tlast;
            r_apply   <= w_req && (!r_pkt_open || w_closing);
            r_pending <= w_req && r_pkt_open && !w_closing;
            if (r_apply) begin
                for (int k = 0; k < NTAPS; k++) r_coef[k] <= cfg_coef[k*COEF_W +: COEF_W];
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int k = 0; k < NTAPS; k++) r_prod[k] <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
            r_m_data   <= '0;
        end else if (w_adv) begin
            for (int k = 0; k < NTAPS; k++) r_prod[k] <= prod_t'(r_x[k]) * prod_t'(r_coef[k]);
            r_s1_valid <= r_s0_valid;
            r_s1_last  <= r_s0_last;
            r_m_valid  <= r_s1_valid;
            r_m_last   <= r_s1_last;
            r_m_data   <= w_rs_data;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (cfg_clear) r_count <= '0;
            else if (r_m_valid && m_axis_tready) r_count <= r_count + 32'd1;
            if (cfg_clear) r_overflow <= 1'b0;
            else if (w_adv && r_s1_valid && w_sat) r_overflow <= 1'b1;
        end
    end

    assign m_axis_tdata  = r_m_data;
    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tlast  = r_m_last;
    assign sample_count  = r_count;
    assign overflow      = r_overflow;
    assign coef_pending  = r_pending;

endmodule
